// File: rtl/scan_mux_nbit.sv
// scan_mux_nbit: time-multiplexed display channel scanner.
// Optional SCAN_HOLD_EN adds hold/hold_sel to pin the scan to one channel.
module scan_mux_nbit #(
  parameter int N = 6,
  parameter int CHANNELS = 8,
  parameter int DIV = 100000,
  parameter int BLANK = 16,
  localparam int SELW = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [CHANNELS*N-1:0] x,
  input  logic [CHANNELS-1:0]   mask,
`ifdef SCAN_HOLD_EN
  input  logic                  hold,
  input  logic [SELW-1:0]       hold_sel,
`endif
  output logic [N-1:0]          y,
  output logic [SELW-1:0]       sel,
  output logic [CHANNELS-1:0]   an_n,
  output logic                  slot_start
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] TC  = PW'(DIV - 1);
  localparam logic [PW-1:0] BLK = PW'(BLANK);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [PW-1:0]       presc, presc_d;
  logic [0:0]          state, state_d;
  logic                tc, adv, any;
  logic                hold_i;
  logic [SELW-1:0]     hsel_i;
  logic [SELW-1:0]     nxt, sel_pre, sel_d;
  logic                act_cur, act_d;
  logic [CHANNELS-1:0] an_d;
  logic [N-1:0]        xsel;
  logic                hi_f, lo_f;
  logic [SELW-1:0]     hi_i, lo_i;

`ifdef SCAN_HOLD_EN
  assign hold_i = hold;
  assign hsel_i = hold_sel;
`else
  assign hold_i = 1'b0;
  assign hsel_i = '0;
`endif

  function automatic logic active(
    input logic [SELW-1:0]     s,
    input logic [CHANNELS-1:0] m,
    input logic                h
  );
    logic a;
    a = h;
    for (int k = 0; k < CHANNELS; k++)
      if (int'(s) == k && m[k]) a = 1'b1;
    return a;
  endfunction

  function automatic logic [CHANNELS-1:0] dec_n(
    input logic [SELW-1:0] s
  );
    logic [CHANNELS-1:0] r;
    r = '1;
    for (int k = 0; k < CHANNELS; k++)
      if (int'(s) == k) r[k] = 1'b0;
    return r;
  endfunction

  assign any     = |mask;
  assign tc      = (presc == TC);
  assign adv     = tc && (any || hold_i);
  assign presc_d = tc ? '0 : presc + 1'b1;

  // next = first set bit above sel, else lowest set bit (wraps to sel)
  always_comb begin
    hi_f = 1'b0;
    lo_f = 1'b0;
    hi_i = '0;
    lo_i = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (mask[k] && k > int'(sel) && !hi_f) begin
        hi_f = 1'b1;
        hi_i = SELW'(k);
      end
      if (mask[k] && !lo_f) begin
        lo_f = 1'b1;
        lo_i = SELW'(k);
      end
    end
    nxt = hi_f ? hi_i : (lo_f ? lo_i : sel);
  end

  always_comb begin
    sel_pre = sel;
    if (adv) sel_pre = hold_i ? hsel_i : nxt;
    sel_d = (int'(sel_pre) >= CHANNELS) ? '0 : sel_pre;
  end

  always_comb begin
    xsel = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (int'(sel) == k) xsel = x[k*N +: N];
  end

  assign state_d = (presc_d >= BLK) ? ST_DRIVE : ST_BLANK;
  assign act_cur = active(sel, mask, hold_i);
  assign act_d   = active(sel_d, mask, hold_i);
  assign an_d    = (state_d == ST_DRIVE && act_d) ? dec_n(sel_d) : '1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc      <= '0;
      sel        <= '0;
      state      <= ST_BLANK;
      an_n       <= '1;
      slot_start <= 1'b0;
      y          <= '0;
    end else if (en) begin
      presc      <= presc_d;
      sel        <= sel_d;
      state      <= state_d;
      an_n       <= an_d;
      slot_start <= adv;
      if (!any && !hold_i)
        y <= '0;
      else if (state == ST_DRIVE && act_cur)
        y <= xsel;
    end
  end

endmodule

// File: doc/scan_mux_nbit.md
Name: scan_mux_nbit

Overview:
- Parametrised successor to the combinational 8:1 n-bit mux: a time-multiplexed channel scanner for the occupancy display.
- Cycles a registered select through CHANNELS input words at a programmable slot rate. Presents the selected word on y, with a matching active-low one-hot digit enable.
- Skips masked channels and inserts a blanking interval at each slot change to suppress ghosting.
- Sits between the occupancy/BCD logic and the seven-segment decoder/anode drivers.

Parameters:
- N, 6, data width per channel.
- CHANNELS, 8, number of input channels (2..16).
- DIV, 100000, clock cycles per slot (>= BLANK+2).
- BLANK, 16, cycles at the start of each slot with all enables off (0 = no blanking).
- SELW, $clog2(CHANNELS), derived select width; not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  scan enable; when low, the prescaler and channel pointer freeze and outputs hold.
- x  in  CHANNELS*N  flattened inputs; channel k occupies x[k*N +: N].
- mask  in  CHANNELS  1 = channel k participates in the scan; 0 = skipped.
- y  out  N  registered selected word.
- sel  out  SELW  index of the current channel.
- an_n  out  CHANNELS  active-low one-hot enable for sel; all ones while blanking.
- slot_start  out  1  one-cycle pulse on the first cycle of each new slot.

Behaviour:
- Reset (async assert, sync release): prescaler=0, sel=0, y=0, an_n=all ones, slot_start=0, state=BLANK.
- Prescaler counts 0..DIV-1 while en=1. At terminal count (DIV-1) it wraps to 0 and the pointer advances.
- Next channel: the lowest index j > sel, with wrap-around modulo CHANNELS, such that mask[j]=1.
  - If only sel itself is unmasked, sel is unchanged but the slot still restarts: blank, then slot_start.
- If mask is all zeros: an_n=all ones, y=0, sel holds, slot_start never pulses, prescaler keeps running.
- States:
  - BLANK: prescaler < BLANK; an_n=all ones.
  - DRIVE: prescaler >= BLANK; an_n[sel]=0, all other bits 1.
- slot_start=1 in the cycle the prescaler equals 0 after an advance (registered with sel). Not asserted on the first slot after reset.
- y <= x[sel*N +: N] every cycle in DRIVE, giving 1-cycle latency from an x change to y. In BLANK, y holds its last value.
- A mask change takes effect at the next advance. If the current sel becomes masked mid-slot, an_n goes all ones on the next cycle and the slot finishes blank.
- en low mid-slot: all registers hold; resuming continues from the same prescaler value.
- Reset mid-slot: immediate return to reset values, independent of clk.
- Arithmetic is unsigned. Writes with sel >= CHANNELS cannot occur; a default arm forces sel=0.

Optional Feature:
- Macro SCAN_HOLD_EN.
- Defined: adds ports hold (in, 1) and hold_sel (in, SELW). While hold=1:
  - at the next advance, sel is loaded with hold_sel regardless of mask, then stays fixed;
  - slots keep blanking and pulsing slot_start normally.
  - Releasing hold resumes the normal skip-scan from hold_sel.
- Undefined: no extra ports; behaviour exactly as above.

Test Plan:
- N=4, CHANNELS=4, DIV=4, BLANK=1, mask=4'b1111, x={4'hD,4'hC,4'hB,4'hA}, release reset -> sel sequence 0,1,2,3,0 with 4 cycles each. an_n goes 1111 for 1 cycle then 1110/1101/1011/0111. y = A,B,C,D with 1-cycle lag. slot_start pulses every 4 cycles from the first advance.
- mask=4'b1010 -> sel alternates 1,3,1,3; an_n never drives bits 0 or 2; y alternates B,D.
- mask=4'b0000 -> an_n stays 1111, y=0, slot_start=0 for 20 cycles. Then mask=4'b0100 -> within one slot, sel=2 and y=C.
- Drop en for 7 cycles at prescaler=2 -> sel, y, an_n unchanged over the gap; the slot completes 2 cycles after en returns.
- Assert reset_n=0 mid-DRIVE between clock edges -> y=0, sel=0, an_n=1111 immediately, before the next edge.
- SCAN_HOLD_EN defined, hold=1, hold_sel=2, mask=4'b0001 -> sel locks to 2 after the next advance and y=C. Release hold -> next sel=0.
